// File: rtl/riscv_pkg.sv
// Shared core definitions: architectural widths and the writeback entry type.
package riscv_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wb_entry_t;

endpackage

// File: rtl/wb_ctrl_fifo.sv
// Writeback queue storage: circular buffer with registered occupancy and an
// age-ordered view of all entries (index 0 = head / oldest).
module wb_fifo
    import riscv_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  wb_entry_t                  push_entry,
    input  logic                       pop,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level,
    output logic [DEPTH-1:0]           view_valid,
    output wb_entry_t [DEPTH-1:0]      view_entry
);

    localparam int PTR_W = $clog2(DEPTH);

    wb_entry_t              r_mem [DEPTH];
    logic [PTR_W-1:0]       r_wptr;
    logic [PTR_W-1:0]       r_rptr;
    logic [PTR_W:0]         r_level;

    // Pointer and occupancy update; pointers wrap naturally at DEPTH (power of two)
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (push) r_wptr <= r_wptr + PTR_W'(1);
            if (pop)  r_rptr <= r_rptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   r_level <= r_level + (PTR_W+1)'(1);
                2'b01:   r_level <= r_level - (PTR_W+1)'(1);
                default: ;
            endcase
        end
    end

    // Entry storage is left unreset; only entries below level are ever observed
    always_ff @(posedge clk) begin
        if (push) r_mem[r_wptr] <= push_entry;
    end

    // Age-ordered view: slot k is the k-th oldest entry, valid while k < level
    always_comb begin
        for (int unsigned k = 0; k < DEPTH; k++) begin
            view_entry[k] = r_mem[r_rptr + PTR_W'(k)];
            view_valid[k] = ((PTR_W+1)'(k) < r_level);
        end
    end

    assign full  = (r_level == (PTR_W+1)'(DEPTH));
    assign empty = (r_level == '0);
    assign level = r_level;

endmodule

// File: rtl/wb_ctrl.sv
// Writeback controller: arbitrates ALU/load results into the writeback queue
// (load has priority), drains the head into the register file, and provides
// a combinational bypass lookup over queued (not yet written) results.
module wb_ctrl
    import riscv_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    alu_valid,
    input  logic [REG_ADDR_W-1:0]   alu_rd,
    input  logic [XLEN-1:0]         alu_data,
    output logic                    alu_ready,
    input  logic                    ld_valid,
    input  logic [REG_ADDR_W-1:0]   ld_rd,
    input  logic [XLEN-1:0]         ld_data,
    output logic                    ld_ready,
    input  logic                    rf_stall,
    output logic                    rf_wEn,
    output logic [REG_ADDR_W-1:0]   rf_rd,
    output logic [XLEN-1:0]         rf_dataIn,
    input  logic [REG_ADDR_W-1:0]   byp_rs1,
    input  logic [REG_ADDR_W-1:0]   byp_rs2,
    output logic                    byp_hit1,
    output logic                    byp_hit2,
    output logic [XLEN-1:0]         byp_data1,
    output logic [XLEN-1:0]         byp_data2,
    output logic [$clog2(DEPTH):0]  level
);

    logic                   w_full;
    logic                   w_empty;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_ld_fire;
    logic                   w_alu_fire;
    wb_entry_t              w_push_entry;
    logic [DEPTH-1:0]       w_view_valid;
    wb_entry_t [DEPTH-1:0]  w_view_entry;

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (w_push),
        .push_entry (w_push_entry),
        .pop        (w_pop),
        .full       (w_full),
        .empty      (w_empty),
        .level      (level),
        .view_valid (w_view_valid),
        .view_entry (w_view_entry)
    );

    // Handshake and push selection; ready comes from registered occupancy only
    always_comb begin
        ld_ready     = !rst && !w_full;
        alu_ready    = !rst && !w_full && !ld_valid;
        w_ld_fire    = ld_valid && ld_ready;
        w_alu_fire   = alu_valid && alu_ready;
        w_push_entry = w_ld_fire ? '{rd: ld_rd,  data: ld_data}
                                 : '{rd: alu_rd, data: alu_data};
        // x0 results complete the handshake but are dropped
        w_push       = (w_ld_fire  && (ld_rd  != '0)) ||
                       (w_alu_fire && (alu_rd != '0));
    end

    // Register-file drain from the queue head
    always_comb begin
        rf_wEn    = !rst && !w_empty && !rf_stall;
        w_pop     = rf_wEn;
        rf_rd     = w_view_entry[0].rd;
        rf_dataIn = w_view_entry[0].data;
    end

    // Bypass search oldest-to-youngest so the youngest match wins
    always_comb begin
        byp_hit1  = 1'b0;
        byp_hit2  = 1'b0;
        byp_data1 = '0;
        byp_data2 = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            if (w_view_valid[k] && (byp_rs1 != '0) && (w_view_entry[k].rd == byp_rs1)) begin
                byp_hit1  = 1'b1;
                byp_data1 = w_view_entry[k].data;
            end
            if (w_view_valid[k] && (byp_rs2 != '0) && (w_view_entry[k].rd == byp_rs2)) begin
                byp_hit2  = 1'b1;
                byp_data2 = w_view_entry[k].data;
            end
        end
        if (rst) begin
            byp_hit1  = 1'b0;
            byp_hit2  = 1'b0;
            byp_data1 = '0;
            byp_data2 = '0;
        end
    end

endmodule
